// File: rtl/matrix_scan_if.sv
// matrix_scan_if: frame-buffer input and LED shift-chain outputs of the scan driver.
//
// Qualification rule: `data` is only meaningful while `data_stable` is high.
// The driver looks at the pair only in its snapshot cycle, once per scan. There
// is no back-pressure; the reader never waits on the driver.
interface matrix_scan_if #(
   parameter int DATA_SIZE = 8192,
   parameter int ROW_W     = 4
);
   logic [DATA_SIZE-1:0] data;
   logic                 data_stable;
   logic                 sr_clk;
   logic                 sr_data;
   logic                 sr_latch;
   logic                 sr_oe_n;
   logic [ROW_W-1:0]     row;
   logic                 scan_done;
   logic [1:0]           dbg_state;

   // Frame source side (SPI reader or testbench).
   modport master (
      output data, data_stable,
      input  sr_clk, sr_data, sr_latch, sr_oe_n, row, scan_done, dbg_state
   );

   // Scan driver side.
   modport slave (
      input  data, data_stable,
      output sr_clk, sr_data, sr_latch, sr_oe_n, row, scan_done, dbg_state
   );
endinterface

// File: rtl/matrix_scan.sv
// matrix_scan: snapshots the reader's frame buffer when it is idle and
// multiplexes it row by row into the LED column shift-register chain.
// Every output is a register loaded from the next-state decode, so each
// output value describes the state the FSM is in during that same cycle.
module matrix_scan #(
   parameter int DATA_SIZE = 8192,
   parameter int NUM_ROWS  = 16,
   parameter int ROW_BITS  = DATA_SIZE / NUM_ROWS,
   parameter int ROW_W     = 4
) (
   input  logic         clk,
   input  logic         rst,
   matrix_scan_if.slave bus
);
   localparam int K_W   = (ROW_BITS > 1) ? $clog2(ROW_BITS) : 1;
   localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam logic [K_W-1:0]   K_LAST   = K_W'(ROW_BITS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DATA_SIZE - 1);

   typedef enum logic [1:0] {
      S_SNAP  = 2'd0,
      S_SHIFT = 2'd1,
      S_BLANK = 2'd2,
      S_LATCH = 2'd3
   } state_t;

   state_t               r_state, w_state_nxt;
   logic                 r_phase, w_phase_nxt;       // 0: data setup, 1: sr_clk high
   logic [K_W-1:0]       r_k, w_k_nxt;               // bit within the row
   logic [ROW_W-1:0]     r_shift_row, w_shift_row_nxt;
   logic [IDX_W-1:0]     r_idx, w_idx_nxt;           // running snapshot bit address
   logic [DATA_SIZE-1:0] r_snap, w_snap_nxt;
   logic                 r_lit, w_lit_nxt;           // a row has been latched since reset

   logic                 r_sr_clk, w_sr_clk_nxt;
   logic                 r_sr_data, w_sr_data_nxt;
   logic                 r_sr_latch, w_sr_latch_nxt;
   logic                 r_sr_oe_n, w_sr_oe_n_nxt;
   logic [ROW_W-1:0]     r_row, w_row_nxt;
   logic                 r_scan_done, w_scan_done_nxt;

   // Next-state, datapath and next-output decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_phase_nxt     = r_phase;
      w_k_nxt         = r_k;
      w_shift_row_nxt = r_shift_row;
      w_idx_nxt       = r_idx;
      w_snap_nxt      = r_snap;
      w_lit_nxt       = r_lit;

      unique case (r_state)
         S_SNAP: begin
            // A busy reader means a half-written frame: keep the old one.
            if (bus.data_stable) begin
               w_snap_nxt = bus.data;
            end
            w_shift_row_nxt = '0;
            w_k_nxt         = '0;
            w_idx_nxt       = IDX_TOP;
            w_phase_nxt     = 1'b0;
            w_state_nxt     = S_SHIFT;
         end
         S_SHIFT: begin
            if (!r_phase) begin
               w_phase_nxt = 1'b1;
            end else begin
               w_phase_nxt = 1'b0;
               // The address runs continuously across rows; hold at 0 after the last bit.
               if (r_idx != '0) begin
                  w_idx_nxt = r_idx - IDX_W'(1);
               end
               if (r_k == K_LAST) begin
                  w_state_nxt = S_BLANK;
               end else begin
                  w_k_nxt = r_k + K_W'(1);
               end
            end
         end
         S_BLANK: begin
            w_state_nxt = S_LATCH;
         end
         S_LATCH: begin
            w_lit_nxt = 1'b1;
            if (r_shift_row == ROW_LAST) begin
               w_state_nxt = S_SNAP;
            end else begin
               w_shift_row_nxt = r_shift_row + ROW_W'(1);
               w_k_nxt         = '0;
               w_phase_nxt     = 1'b0;
               w_state_nxt     = S_SHIFT;
            end
         end
         default: begin
            w_state_nxt = S_SNAP;
         end
      endcase

      // Outputs for the cycle the FSM is about to enter.
      w_sr_clk_nxt  = (w_state_nxt == S_SHIFT) && w_phase_nxt;
      w_sr_data_nxt = r_sr_data;
      if ((w_state_nxt == S_SHIFT) && !w_phase_nxt) begin
         w_sr_data_nxt = w_snap_nxt[w_idx_nxt];
      end
      w_sr_latch_nxt  = (w_state_nxt == S_LATCH);
      // Display is dark until the first row is latched, and during BLANK/LATCH.
      w_sr_oe_n_nxt   = !(w_lit_nxt &&
                          ((w_state_nxt == S_SHIFT) || (w_state_nxt == S_SNAP)));
      w_row_nxt       = (w_state_nxt == S_LATCH) ? r_shift_row : r_row;
      w_scan_done_nxt = (w_state_nxt == S_LATCH) && (r_shift_row == ROW_LAST);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_SNAP;
         r_phase     <= 1'b0;
         r_k         <= '0;
         r_shift_row <= '0;
         r_idx       <= IDX_TOP;
         r_snap      <= '0;
         r_lit       <= 1'b0;
         r_sr_clk    <= 1'b0;
         r_sr_data   <= 1'b0;
         r_sr_latch  <= 1'b0;
         r_sr_oe_n   <= 1'b1;
         r_row       <= '0;
         r_scan_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_phase     <= w_phase_nxt;
         r_k         <= w_k_nxt;
         r_shift_row <= w_shift_row_nxt;
         r_idx       <= w_idx_nxt;
         r_snap      <= w_snap_nxt;
         r_lit       <= w_lit_nxt;
         r_sr_clk    <= w_sr_clk_nxt;
         r_sr_data   <= w_sr_data_nxt;
         r_sr_latch  <= w_sr_latch_nxt;
         r_sr_oe_n   <= w_sr_oe_n_nxt;
         r_row       <= w_row_nxt;
         r_scan_done <= w_scan_done_nxt;
      end
   end

   assign bus.sr_clk    = r_sr_clk;
   assign bus.sr_data   = r_sr_data;
   assign bus.sr_latch  = r_sr_latch;
   assign bus.sr_oe_n   = r_sr_oe_n;
   assign bus.row       = r_row;
   assign bus.scan_done = r_scan_done;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan: directed and randomized scans of a small 32-bit/4-row
// instance, plus one scan of a default-size instance.
module tb_matrix_scan;
   localparam int DS   = 32;
   localparam int NR   = 4;
   localparam int RB   = DS / NR;
   localparam int RW   = 2;
   localparam int SCAN = NR * (2 * RB + 2) + 1;   // 73
   localparam int BDS  = 8192;
   localparam int BSCAN = 16417;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic rst_big;
   logic rst_q;   // reset as the DUT sampled it at the last edge
   always @(posedge clk) rst_q <= rst;

   matrix_scan_if #(.DATA_SIZE(DS), .ROW_W(RW)) bus ();
   matrix_scan_if #(.DATA_SIZE(BDS), .ROW_W(4)) bus_big ();

   matrix_scan #(.DATA_SIZE(DS), .NUM_ROWS(NR), .ROW_BITS(RB), .ROW_W(RW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   matrix_scan dut_big (
      .clk (clk),
      .rst (rst_big),
      .bus (bus_big)
   );

   // ---------------- scoreboard ----------------
   int n_cmp;
   int n_fail;
   logic [RB-1:0] exp_q[$];      // expected row bytes, in shift order
   logic          got_bits[$];   // bits seen on sr_clk rising edges
   logic [RW-1:0] got_rows[$];   // row value seen at each latch
   logic [DS-1:0] m_snap;        // model of the displayed frame

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_sr_clk"},    32'(bus.sr_clk),    32'd0);
      check({tag, "_sr_data"},   32'(bus.sr_data),   32'd0);
      check({tag, "_sr_latch"},  32'(bus.sr_latch),  32'd0);
      check({tag, "_sr_oe_n"},   32'(bus.sr_oe_n),   32'd1);
      check({tag, "_row"},       32'(bus.row),       32'd0);
      check({tag, "_scan_done"}, 32'(bus.scan_done), 32'd0);
   endtask

   // Present a frame for the coming snapshot cycle and record what the
   // next scan must display: the new frame if stable, else the old one.
   task automatic start_scan(input logic [DS-1:0] frame, input logic stable);
      bus.data        = frame;
      bus.data_stable = stable;
      if (stable) m_snap = frame;
      for (int r = 0; r < NR; r++) begin
         exp_q.push_back(m_snap[DS-1-r*RB -: RB]);
      end
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.scan_done !== 1'b1 && n < SCAN + 8);
      check({tag, "_done_seen"}, 32'(bus.scan_done), 32'd1);
   endtask

   task automatic check_scan(input string tag);
      logic [RB-1:0] e;
      logic [RB-1:0] g;
      logic [RW-1:0] gr;
      int r;
      r = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = '0;
         for (int b = 0; b < RB; b++) begin
            g = {g[RB-2:0], (got_bits.size() > 0) ? got_bits.pop_front() : 1'bx};
         end
         check({tag, "_bits"}, 32'(g), 32'(e));
         gr = (got_rows.size() > 0) ? got_rows.pop_front() : 'x;
         check({tag, "_row"}, 32'(gr), 32'(r % NR));
         r++;
      end
   endtask

   // ---------------- output monitor ----------------
   logic p_clk, p_oe_n, p_latch;
   logic [RW-1:0] p_row;
   int edge_cnt, hi_cnt, cyc_cnt;
   bit lit_seen;

   // Watches shift-chain timing every cycle, away from the clock edge.
   always @(negedge clk) begin
      if (rst_q) begin
         edge_cnt = 0;
         hi_cnt   = 0;
         cyc_cnt  = 1;
         lit_seen = 1'b0;
         got_bits.delete();
         got_rows.delete();
      end else begin
         cyc_cnt++;
         if (bus.sr_oe_n) hi_cnt++;
         if (!p_clk && bus.sr_clk) begin
            got_bits.push_back(bus.sr_data);
            edge_cnt++;
         end
         if (!lit_seen) check("oe_dark_before_first_latch", 32'(bus.sr_oe_n), 32'd1);
         if (!bus.sr_latch) check("row_hold", 32'(bus.row), 32'(p_row));
         if (bus.sr_latch) begin
            check("latch_width",       32'(p_latch),     32'd0);
            check("latch_oe_n",        32'(bus.sr_oe_n), 32'd1);
            check("latch_prev_oe_n",   32'(p_oe_n),      32'd1);
            check("latch_sr_clk",      32'(bus.sr_clk),  32'd0);
            check("latch_prev_sr_clk", 32'(p_clk),       32'd0);
            check("latch_edges",       32'(edge_cnt),    32'(RB));
            if (lit_seen) check("oe_high_cycles", 32'(hi_cnt), 32'd2);
            got_rows.push_back(bus.row);
            edge_cnt = 0;
            hi_cnt   = 0;
            lit_seen = 1'b1;
         end
         if (bus.scan_done) begin
            check("done_with_latch", 32'(bus.sr_latch), 32'd1);
            check("scan_period",     32'(cyc_cnt),      32'(SCAN));
            cyc_cnt = 0;
         end
      end
      p_clk   = bus.sr_clk;
      p_oe_n  = bus.sr_oe_n;
      p_latch = bus.sr_latch;
      p_row   = bus.row;
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int edges, ones, dones, t1, cyc;
      logic first_bit, pclk;
      n_cmp  = 0;
      n_fail = 0;
      m_snap = '0;
      rst     = 1'b1;
      rst_big = 1'b1;
      bus.data            = '0;
      bus.data_stable     = 1'b0;
      bus_big.data        = '0;
      bus_big.data_stable = 1'b0;

      // Reset held three cycles.
      repeat (3) begin
         tick();
         check_reset("rst_hold");
      end

      // Row order with a stable frame.
      start_scan(32'hF00F5511, 1'b1);
      rst = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.sr_clk !== 1'b1 && n < 10);
      check("first_sr_clk_rise", 32'(n), 32'd2);
      wait_done("scan_a");
      tick();
      check_scan("row_order");

      // Tearing guard: reader busy at snapshot, new data must not appear.
      start_scan(32'h12345678, 1'b0);
      repeat (20) tick();
      bus.data_stable = 1'b1;
      wait_done("scan_b");
      tick();
      check_scan("tear_guard");
      start_scan(32'h12345678, 1'b1);
      wait_done("scan_c");
      tick();
      check_scan("tear_release");

      // Random frames, with input churn mid-scan that must be ignored.
      for (int i = 0; i < 5; i++) begin
         start_scan(DS'($urandom), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(1, 60)) tick();
         bus.data        = DS'($urandom);
         bus.data_stable = 1'($urandom_range(0, 1));
         wait_done("scan_rand");
         tick();
         check_scan("rand");
      end

      // Reset in the middle of row 2's shift.
      start_scan(32'hA5C33CA5, 1'b1);
      repeat (45) tick();
      rst = 1'b1;
      tick();
      check_reset("mid_rst");
      exp_q.delete();
      m_snap = '0;
      rst = 1'b0;
      start_scan(32'hDEADBEEF, 1'b0);
      wait_done("scan_empty");
      tick();
      check_scan("post_rst_empty");
      start_scan(32'hDEADBEEF, 1'b1);
      wait_done("scan_recap");
      tick();
      check_scan("post_rst_recap");

      // Default-size instance: single set bit at the top of the frame.
      bus_big.data[BDS-1] = 1'b1;
      bus_big.data_stable = 1'b1;
      tick();
      rst_big = 1'b0;
      edges = 0; ones = 0; dones = 0; t1 = 0; cyc = 0;
      first_bit = 1'b0;
      pclk = 1'b0;
      while (dones < 2 && cyc < 2 * BSCAN + 20) begin
         tick();
         cyc++;
         if (!pclk && bus_big.sr_clk) begin
            edges++;
            if (edges == 1) first_bit = bus_big.sr_data;
            if (dones == 0 && bus_big.sr_data) ones++;
         end
         pclk = bus_big.sr_clk;
         if (bus_big.scan_done) begin
            dones++;
            if (dones == 1) begin
               t1 = cyc;
               check("big_edges_per_scan", 32'(edges), 32'(BDS));
            end
         end
      end
      check("big_dones",     32'(dones),     32'd2);
      check("big_first_bit", 32'(first_bit), 32'd1);
      check("big_ones",      32'(ones),      32'd1);
      check("big_period",    32'(cyc - t1),  32'(BSCAN));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
